prime_trial_engine: RTL and testbench

Parametrised successor to the serial prime detector. It takes an NBITS-wide candidate over a valid/ready input stream and runs trial division with an internal shift-subtract remainder unit. Divisors are 2, then odd values only. With SQRT_STOP=1 the search ends early once d*d > n. Results go out on a valid/ready output stream: a primality flag plus the smallest nontrivial factor. The block sits between the input deserialiser and the result/display logic, and replaces the counter+divider+FSM cluster.

---
 rtl/prime_trial_engine.sv | 147 ++++++++++++++
 tb/tb_prime_trial_engine.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/prime_trial_engine.sv
// rtl/prime_trial_engine.sv - trial-division primality engine with valid/ready streams
// Divisors are 2 then odd values; each divisor costs one TEST, NBITS DIV and one EVAL cycle.
module prime_trial_engine #(
   parameter int NBITS     = 16,
   parameter int SQRT_STOP = 1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             abort,
   input  logic             in_val,
   output logic             in_rdy,
   input  logic [NBITS-1:0] in_num,
   output logic             out_val,
   input  logic             out_rdy,
   output logic             out_is_prime,
   output logic [NBITS-1:0] out_factor,
   output logic             busy
);

   localparam int CW = $clog2(NBITS);
   localparam logic [NBITS-1:0] TWO   = NBITS'(2);
   localparam logic [NBITS-1:0] THREE = NBITS'(3);

   typedef enum logic [2:0] {IDLE, CHECK, TEST, DIV, EVAL, DONE} state_t;

   state_t             state_q, state_d;
   logic [NBITS-1:0]   n_q, n_d;
   logic [NBITS-1:0]   d_q, d_d;
   logic [NBITS-1:0]   factor_q, factor_d;
   logic               prime_q, prime_d;
   logic [NBITS:0]     rem_q, rem_d;
   logic [NBITS:0]     rem_shift, rem_step;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [2*NBITS-1:0] d_wide, n_wide, d_sq;
   logic               stop;

   // Square compared at double width so d*d never wraps.
   always_comb begin
      d_wide = {{NBITS{1'b0}}, d_q};
      n_wide = {{NBITS{1'b0}}, n_q};
      d_sq   = d_wide * d_wide;
      stop   = (SQRT_STOP != 0) ? (d_sq > n_wide) : (d_q >= n_q);
   end

   // One restoring shift-subtract step, dividend bits taken MSB first.
   always_comb begin
      rem_shift = {rem_q[NBITS-1:0], n_q[cnt_q]};
      if (rem_shift >= {1'b0, d_q})
         rem_step = rem_shift - {1'b0, d_q};
      else
         rem_step = rem_shift;
   end

   always_comb begin
      state_d  = state_q;
      n_d      = n_q;
      d_d      = d_q;
      factor_d = factor_q;
      prime_d  = prime_q;
      rem_d    = rem_q;
      cnt_d    = cnt_q;
      case (state_q)
         IDLE: begin
            if (in_val) begin
               n_d     = in_num;
               d_d     = TWO;
               state_d = CHECK;
            end
         end
         CHECK: begin
            if (n_q < TWO) begin
               prime_d  = 1'b0;
               factor_d = '0;
               state_d  = DONE;
            end else if ((n_q == TWO) || (n_q == THREE)) begin
               prime_d  = 1'b1;
               factor_d = n_q;
               state_d  = DONE;
            end else begin
               state_d = TEST;
            end
         end
         TEST: begin
            if (stop) begin
               prime_d  = 1'b1;
               factor_d = n_q;
               state_d  = DONE;
            end else begin
               rem_d   = '0;
               cnt_d   = CW'(NBITS - 1);
               state_d = DIV;
            end
         end
         DIV: begin
            rem_d = rem_step;
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == '0)
               state_d = EVAL;
         end
         EVAL: begin
            if (rem_q == '0) begin
               prime_d  = 1'b0;
               factor_d = d_q;
               state_d  = DONE;
            end else begin
               d_d     = (d_q == TWO) ? THREE : (d_q + TWO);
               state_d = TEST;
            end
         end
         DONE: begin
            if (out_rdy)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      // Abort wins everywhere, including over a candidate offered in IDLE.
      if (abort)
         state_d = IDLE;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         n_q      <= '0;
         d_q      <= '0;
         factor_q <= '0;
         prime_q  <= 1'b0;
         rem_q    <= '0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         n_q      <= n_d;
         d_q      <= d_d;
         factor_q <= factor_d;
         prime_q  <= prime_d;
         rem_q    <= rem_d;
         cnt_q    <= cnt_d;
      end
   end

   assign in_rdy       = (state_q == IDLE);
   assign out_val      = (state_q == DONE);
   assign busy         = (state_q != IDLE);
   assign out_is_prime = prime_q;
   assign out_factor   = factor_q;

endmodule

// File: tb/tb_prime_trial_engine.sv
// tb/tb_prime_trial_engine.sv - self-checking bench for prime_trial_engine
// Instance 0 runs exhaustive mode, instance 1 runs square-root stop mode.
module tb_prime_trial_engine;

   localparam int NB  = 16;
   localparam int LPD = NB + 2;
   localparam int BUDGET = 4000;

   typedef struct {
      int mode;
      int n;
      int prime;
      int factor;
      int lat;
   } vec_t;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          abort [2];
   logic          in_val [2];
   logic          in_rdy [2];
   logic [NB-1:0] in_num [2];
   logic          out_val [2];
   logic          out_rdy [2];
   logic          out_is_prime [2];
   logic [NB-1:0] out_factor [2];
   logic          busy [2];

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   prime_trial_engine #(.NBITS(NB), .SQRT_STOP(0)) dut0 (
      .clk(clk), .reset_n(reset_n), .abort(abort[0]),
      .in_val(in_val[0]), .in_rdy(in_rdy[0]), .in_num(in_num[0]),
      .out_val(out_val[0]), .out_rdy(out_rdy[0]),
      .out_is_prime(out_is_prime[0]), .out_factor(out_factor[0]), .busy(busy[0])
   );

   prime_trial_engine #(.NBITS(NB), .SQRT_STOP(1)) dut1 (
      .clk(clk), .reset_n(reset_n), .abort(abort[1]),
      .in_val(in_val[1]), .in_rdy(in_rdy[1]), .in_num(in_num[1]),
      .out_val(out_val[1]), .out_rdy(out_rdy[1]),
      .out_is_prime(out_is_prime[1]), .out_factor(out_factor[1]), .busy(busy[1])
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Reference: walk the divisor sequence with plain modulo arithmetic.
   function automatic void model(input int mode, input int n,
                                 output int prime, output int factor, output int lat);
      int d, cnt;
      bit fin;
      if (n < 2) begin
         prime = 0; factor = 0; lat = 1;
         return;
      end
      if (n < 4) begin
         prime = 1; factor = n; lat = 1;
         return;
      end
      d = 2; cnt = 0; fin = 0;
      prime = 0; factor = 0; lat = 0;
      while (!fin) begin
         if ((mode == 1) ? (d * d > n) : (d >= n)) begin
            prime = 1; factor = n; lat = 2 + cnt * LPD; fin = 1;
         end else begin
            cnt++;
            if (n % d == 0) begin
               prime = 0; factor = d; lat = 1 + cnt * LPD; fin = 1;
            end else begin
               d = (d == 2) ? 3 : d + 2;
            end
         end
      end
   endfunction

   task automatic start_job(input int m, input int n, output int waited);
      @(negedge clk);
      in_num[m] = NB'(n);
      in_val[m] = 1'b1;
      waited = 0;
      while (!in_rdy[m] && waited < 100) begin
         @(negedge clk);
         waited++;
      end
      chk("in_rdy_at_offer", 32'(in_rdy[m]), 32'd1);
      @(posedge clk);
      #1;
      in_val[m] = 1'b0;
      in_num[m] = NB'($urandom);
   endtask

   task automatic wait_result(input int m, input string name,
                              input int ep, input int ef, input int el);
      int lat;
      lat = 0;
      while (!out_val[m] && lat < BUDGET) begin
         @(posedge clk);
         lat++;
         #1;
      end
      chk({name, "_out_val"}, 32'(out_val[m]), 32'd1);
      chk({name, "_latency"}, 32'(lat), 32'(el));
      chk({name, "_is_prime"}, 32'(out_is_prime[m]), 32'(ep));
      chk({name, "_factor"}, 32'(out_factor[m]), 32'(ef));
      if (!out_val[m]) begin
         abort[m] = 1'b1;
         @(posedge clk);
         #1;
         abort[m] = 1'b0;
      end
   endtask

   task automatic run_job(input int m, input int n, input string name,
                          input int ep, input int ef, input int el);
      int w;
      start_job(m, n, w);
      wait_result(m, name, ep, ef, el);
   endtask

   vec_t vecs [14];

   initial begin
      int w, ep, ef, el, seen, stable, n;

      vecs[0]  = '{1, 9,     0, 3,     37};
      vecs[1]  = '{1, 7,     1, 7,     20};
      vecs[2]  = '{1, 0,     0, 0,     1};
      vecs[3]  = '{1, 1,     0, 0,     1};
      vecs[4]  = '{1, 2,     1, 2,     1};
      vecs[5]  = '{1, 3,     1, 3,     1};
      vecs[6]  = '{1, 65521, 1, 65521, 2 + 128 * LPD};
      vecs[7]  = '{1, 65535, 0, 3,     37};
      vecs[8]  = '{1, 65025, 0, 3,     37};
      vecs[9]  = '{1, 4,     0, 2,     19};
      vecs[10] = '{1, 25,    0, 5,     55};
      vecs[11] = '{1, 49,    0, 7,     73};
      vecs[12] = '{0, 7,     1, 7,     56};
      vecs[13] = '{0, 25,    0, 5,     55};

      for (int i = 0; i < 2; i++) begin
         abort[i] = 1'b0; in_val[i] = 1'b0; in_num[i] = '0; out_rdy[i] = 1'b1;
      end
      reset_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         chk("reset_in_rdy", 32'(in_rdy[i]), 32'd1);
         chk("reset_out_val", 32'(out_val[i]), 32'd0);
         chk("reset_busy", 32'(busy[i]), 32'd0);
         chk("reset_factor", 32'(out_factor[i]), 32'd0);
         chk("reset_is_prime", 32'(out_is_prime[i]), 32'd0);
      end
      reset_n = 1'b1;

      for (int i = 0; i < 14; i++)
         run_job(vecs[i].mode, vecs[i].n, $sformatf("vec%0d", i),
                 vecs[i].prime, vecs[i].factor, vecs[i].lat);

      // Consumer stalls: result and handshake must hold.
      @(negedge clk);
      out_rdy[1] = 1'b0;
      run_job(1, 15, "stall", 0, 3, 37);
      stable = 1;
      for (int i = 0; i < 50; i++) begin
         @(posedge clk);
         #1;
         if (!(out_val[1] && !out_is_prime[1] && out_factor[1] == NB'(3) && !in_rdy[1]))
            stable = 0;
      end
      chk("stall_hold_stable", 32'(stable), 32'd1);
      @(negedge clk);
      out_rdy[1] = 1'b1;
      start_job(1, 77, w);
      chk("back_to_back_wait", 32'(w), 32'd0);
      wait_result(1, "b2b", 0, 7, 73);

      // Abort while dividing.
      start_job(1, 65521, w);
      repeat (6) @(posedge clk);
      @(negedge clk);
      abort[1] = 1'b1;
      @(posedge clk);
      #1;
      abort[1] = 1'b0;
      chk("abort_in_rdy", 32'(in_rdy[1]), 32'd1);
      chk("abort_busy", 32'(busy[1]), 32'd0);
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1;
         if (out_val[1]) seen = 1;
      end
      chk("abort_no_out_val", 32'(seen), 32'd0);
      @(negedge clk);
      abort[1] = 1'b1; in_val[1] = 1'b1; in_num[1] = NB'(9);
      @(posedge clk);
      #1;
      abort[1] = 1'b0; in_val[1] = 1'b0;
      chk("abort_idle_priority", 32'(busy[1]), 32'd0);
      run_job(1, 91, "after_abort", 0, 7, 73);

      // Asynchronous reset while in TEST.
      start_job(1, 9, w);
      @(posedge clk);
      #3;
      reset_n = 1'b0;
      #1;
      chk("areset_busy", 32'(busy[1]), 32'd0);
      chk("areset_in_rdy", 32'(in_rdy[1]), 32'd1);
      chk("areset_out_val", 32'(out_val[1]), 32'd0);
      chk("areset_factor", 32'(out_factor[1]), 32'd0);
      chk("areset_is_prime", 32'(out_is_prime[1]), 32'd0);
      #1;
      reset_n = 1'b1;
      run_job(1, 35, "after_reset", 0, 5, 55);

      for (int i = 0; i < 200; i++) begin
         n = int'($urandom_range(0, 65535));
         model(1, n, ep, ef, el);
         run_job(1, n, $sformatf("rand_s1_n%0d", n), ep, ef, el);
      end
      for (int i = 0; i < 150; i++) begin
         n = int'($urandom_range(0, 63));
         model(0, n, ep, ef, el);
         run_job(0, n, $sformatf("rand_s0_n%0d", n), ep, ef, el);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
